// File: rtl/prefix_adder_pkg.sv
// prefix_adder_pkg
//   Shared types and helpers for the Kogge-Stone prefix adder.
//   - DEFAULT_W : default operand width
//   - levels()  : number of prefix-tree levels for a given width
//   - gp_t      : (generate, propagate) pair carried through the tree
package prefix_adder_pkg;

   localparam int DEFAULT_W = 8;

   function automatic int levels(input int w);
      return (w <= 1) ? 0 : $clog2(w);
   endfunction

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

endpackage

// File: rtl/prefix_adder_cell.sv
// prefix_cell
//   One node of the prefix tree: res = hi o lo, where
//   (G,P) o (G',P') = (G | P&G', P&P').
//   Ports:
//     hi  : gp_t pair of the more-significant span
//     lo  : gp_t pair of the less-significant span
//     res : combined pair
//   Parameter BLACK: 1 computes G and P; 0 computes G only and passes
//   hi.p through (used where the combined span already reaches carry-in,
//   so its P is never consumed).
module prefix_cell
   import prefix_adder_pkg::*;
#(
   parameter bit BLACK = 1'b1
)
(
   input  gp_t hi,
   input  gp_t lo,
   output gp_t res
);

   assign res.g = hi.g | (hi.p & lo.g);

   generate
      if (BLACK) begin : g_black
         assign res.p = hi.p & lo.p;
      end else begin : g_grey
         logic unused_lo_p;
         assign unused_lo_p = lo.p;
         assign res.p       = hi.p;
      end
   endgenerate

endmodule

// File: rtl/prefix_adder.sv
// prefix_adder
//   W-bit adder with carry-in on a Kogge-Stone prefix carry tree; the
//   result is registered once ({cout,s} valid one clock after sampling).
//   Optional macro PREFIX_ADDER_OVF_EN adds the registered signed-overflow
//   output ovf = c[W-1]^c[W].
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     in_valid  : operands valid this cycle
//     a, b      : W-bit operands
//     cin       : carry-in
//     out_valid : registered in_valid
//     s         : registered sum
//     cout      : registered carry-out
//     ovf       : registered two's-complement overflow (PREFIX_ADDER_OVF_EN only)
module prefix_adder
   import prefix_adder_pkg::*;
#(
   parameter int W = DEFAULT_W
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   output logic [W-1:0] s,
   output logic         cout
`ifdef PREFIX_ADDER_OVF_EN
   ,output logic        ovf
`endif
);

   localparam int LVL = levels(W);

   logic [W-1:0] g;
   logic [W-1:0] p;
   logic [W:0]   c;
   logic [W-1:0] sum;

   // Column -1 holds carry-in as a pure generate. Bit 0 is folded with it
   // at level 0, so every column i>=0 already spans down to -1 on its low
   // side; this lets LVL=$clog2(W) levels finish all carries (and W=1
   // needs no further levels).
   gp_t tree [0:LVL][-1:W-1];

   assign tree[0][-1] = '{g: cin, p: 1'b0};

   genvar l, i;
   generate
      for (i = 0; i < W; i++) begin : g_leaf
         assign g[i] = a[i] & b[i];
         assign p[i] = a[i] ^ b[i];
         if (i == 0) begin : g_fold_cin
            prefix_cell #(.BLACK(1'b0)) u_cell (
               .hi  ('{g: g[0], p: p[0]}),
               .lo  (tree[0][-1]),
               .res (tree[0][0])
            );
         end else begin : g_raw
            assign tree[0][i] = '{g: g[i], p: p[i]};
         end
      end

      for (l = 1; l <= LVL; l++) begin : g_lvl
         localparam int SPAN = 1 << (l - 1);
         for (i = -1; i < W; i++) begin : g_node
            if (i - SPAN < 0) begin : g_pass
               assign tree[l][i] = tree[l-1][i];
            end else begin : g_cell
               // After this level column i covers bits [i-2^l+1 .. i]; it is
               // complete (reaches cin) when i <= 2^l-1, so only G matters.
               prefix_cell #(.BLACK(i > (1 << l) - 1)) u_cell (
                  .hi  (tree[l-1][i]),
                  .lo  (tree[l-1][i-SPAN]),
                  .res (tree[l][i])
               );
            end
         end
      end

      for (i = 0; i <= W; i++) begin : g_carry
         assign c[i] = tree[LVL][i-1].g;
      end
   endgenerate

   assign sum = p ^ c[W-1:0];

   // ---- output register stage ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         s         <= '0;
         cout      <= 1'b0;
`ifdef PREFIX_ADDER_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            s    <= sum;
            cout <= c[W];
`ifdef PREFIX_ADDER_OVF_EN
            ovf  <= c[W-1] ^ c[W];
`endif
         end
      end
   end

endmodule

// File: tb/tb_prefix_adder.sv
// tb_prefix_adder
//   Directed and randomized checks of prefix_adder (W=8) against an
//   arithmetic reference model. Builds with or without PREFIX_ADDER_OVF_EN.
module tb_prefix_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic [W-1:0] s;
   logic         cout;
`ifdef PREFIX_ADDER_OVF_EN
   logic         ovf;
`endif

   // reference model state: what the outputs should show now
   logic         m_vld = 1'b0;
   logic [W-1:0] m_s = '0;
   logic         m_cout = 1'b0;
   logic         m_ovf = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   prefix_adder #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .s         (s),
      .cout      (cout)
`ifdef PREFIX_ADDER_OVF_EN
      ,.ovf      (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".out_valid"}, {{W{1'b0}}, out_valid}, {{W{1'b0}}, m_vld});
      check({tag, ".s"},         {1'b0, s},                {1'b0, m_s});
      check({tag, ".cout"},      {{W{1'b0}}, cout},      {{W{1'b0}}, m_cout});
`ifdef PREFIX_ADDER_OVF_EN
      check({tag, ".ovf"},       {{W{1'b0}}, ovf},       {{W{1'b0}}, m_ovf});
`endif
   endtask

   task automatic model_reset();
      m_vld  = 1'b0;
      m_s    = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
   endtask

   // Advance one clock, update the model from the inputs sampled at the
   // edge, then compare shortly after the edge.
   task automatic cycle(input string tag);
      int usum;
      int ssum;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         m_vld = in_valid;
         if (in_valid) begin
            usum   = int'(a) + int'(b) + int'(cin);
            ssum   = int'($signed(a)) + int'($signed(b)) + int'(cin);
            m_s    = W'(usum % (1 << W));
            m_cout = (usum >= (1 << W));
            m_ovf  = (ssum > (1 << (W - 1)) - 1) || (ssum < -(1 << (W - 1)));
         end
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic drive(input logic v, input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
      in_valid = v;
      a        = va;
      b        = vb;
      cin      = vc;
   endtask

   initial begin
      // reset held with live operands
      drive(1'b1, 8'h55, 8'h0A, 1'b1);
      #2;
      check_outputs("reset_initial");
      for (int k = 0; k < 3; k++) cycle("reset_hold");
      #2;
      rst_n = 1'b1;

      // carry ripple through all positions
      drive(1'b1, 8'hFF, 8'h00, 1'b1);
      cycle("ripple");

      // hold behaviour
      drive(1'b1, 8'd3, 8'd4, 1'b0);
      cycle("add_3_4");
      check("sum_is_7", {1'b0, s}, 9'd7);
      drive(1'b0, 8'd9, 8'd4, 1'b0);
      cycle("hold");
      check("hold_s_7", {1'b0, s}, 9'd7);

      // signed overflow corners and other boundaries
      drive(1'b1, 8'h7F, 8'h01, 1'b0); cycle("pos_ovf");
      drive(1'b1, 8'h80, 8'h80, 1'b0); cycle("neg_ovf");
      drive(1'b1, 8'hFF, 8'hFF, 1'b1); cycle("max_sum");
      drive(1'b1, 8'h00, 8'h00, 1'b0); cycle("zero");
      drive(1'b1, 8'h00, 8'h00, 1'b1); cycle("cin_only");
      drive(1'b1, 8'hAA, 8'h55, 1'b1); cycle("alt_prop");
      drive(1'b1, 8'h80, 8'h7F, 1'b1); cycle("msb_prop");

      // randomized stream with occasional idle cycles
      for (int k = 0; k < 3000; k++) begin
         drive(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));
         cycle("random");
      end

      // asynchronous reset between edges while streaming
      drive(1'b1, 8'hC3, 8'h5A, 1'b1);
      cycle("pre_async");
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      drive(1'b1, 8'h9E, 8'h77, 1'b0);
      #1;
      rst_n = 1'b1;
      cycle("post_release");
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
         cycle("post_release_stream");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
